// File: rtl/universal_shift_counter_n.sv
// WIDTH-bit universal shift register / modulo counter with 16 opcodes,
// clock enable, registered carry/shift-out flag and a zero flag.
module universal_shift_counter_n #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int              SHW       = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             EN,
    input  logic [3:0]       A,
    input  logic [WIDTH-1:0] D,
    input  logic [SHW-1:0]   SHAMT,
    input  logic             RSI,
    input  logic             LSI,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             ZERO
);

    typedef enum logic [3:0] {
        OP_HOLD = 4'b0000,
        OP_SHL  = 4'b0001,
        OP_SHR  = 4'b0010,
        OP_CLR  = 4'b0011,
        OP_SET  = 4'b0100,
        OP_UPW  = 4'b0101,
        OP_DNW  = 4'b0110,
        OP_LOAD = 4'b0111,
        OP_ROL  = 4'b1000,
        OP_ROR  = 4'b1001,
        OP_ASR  = 4'b1010,
        OP_BSL  = 4'b1011,
        OP_BSR  = 4'b1100,
        OP_UPS  = 4'b1101,
        OP_DNS  = 4'b1110,
        OP_REV  = 4'b1111
    } op_t;

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    op_t              op;
    logic [WIDTH-1:0] q_next;
    logic             co_next;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] rev;

    assign op = op_t'(A);

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rev[i] = Q[WIDTH-1-i];
        end
    end

    always_comb begin
        q_next  = Q;
        co_next = 1'b0;
        ext     = '0;
        case (op)
            OP_HOLD: q_next = Q;
            OP_SHL: begin
                q_next  = {Q[WIDTH-2:0], RSI};
                co_next = Q[WIDTH-1];
            end
            OP_SHR: begin
                q_next  = {LSI, Q[WIDTH-1:1]};
                co_next = Q[0];
            end
            OP_CLR:  q_next = '0;
            OP_SET:  q_next = '1;
            OP_UPW: begin
                if (Q >= MAX_Q) begin
                    q_next  = '0;
                    co_next = 1'b1;
                end else begin
                    q_next = Q + ONE_Q;
                end
            end
            OP_DNW: begin
                if (Q == '0) begin
                    q_next  = MAX_Q;
                    co_next = 1'b1;
                end else begin
                    q_next = Q - ONE_Q;
                end
            end
            OP_LOAD: q_next = D;
            OP_ROL: begin
                q_next  = {Q[WIDTH-2:0], Q[WIDTH-1]};
                co_next = Q[WIDTH-1];
            end
            OP_ROR: begin
                q_next  = {Q[0], Q[WIDTH-1:1]};
                co_next = Q[0];
            end
            OP_ASR: begin
                q_next  = {Q[WIDTH-1], Q[WIDTH-1:1]};
                co_next = Q[0];
            end
            // One guard bit on the shifted-out side yields the last bit lost as CO.
            OP_BSL: begin
                if (int'(SHAMT) >= WIDTH) begin
                    q_next = '0;
                end else if (SHAMT != '0) begin
                    ext     = {1'b0, Q} << SHAMT;
                    q_next  = ext[WIDTH-1:0];
                    co_next = ext[WIDTH];
                end
            end
            OP_BSR: begin
                if (int'(SHAMT) >= WIDTH) begin
                    q_next = '0;
                end else if (SHAMT != '0) begin
                    ext     = {Q, 1'b0} >> SHAMT;
                    q_next  = ext[WIDTH:1];
                    co_next = ext[0];
                end
            end
            OP_UPS: begin
                if (Q >= MAX_Q) begin
                    q_next  = MAX_Q;
                    co_next = 1'b1;
                end else begin
                    q_next = Q + ONE_Q;
                end
            end
            OP_DNS: begin
                if (Q == '0) begin
                    q_next  = '0;
                    co_next = 1'b1;
                end else begin
                    q_next = Q - ONE_Q;
                end
            end
            OP_REV:  q_next = rev;
            default: q_next = Q;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            Q  <= '0;
            CO <= 1'b0;
        end else if (EN) begin
            Q  <= q_next;
            CO <= co_next;
        end
    end

    assign ZERO = (Q == '0);

endmodule

// File: tb/tb_universal_shift_counter_n.sv
// Directed bench for universal_shift_counter_n: an arithmetic model checked
// every cycle on 8-bit (MAX_COUNT=9) and 6-bit instances, plus literal pins.
module tb_universal_shift_counter_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] a = 4'd0;
    logic [7:0] d = 8'd0;
    logic [2:0] shamt = 3'd0;
    logic       rsi = 1'b0;
    logic       lsi = 1'b0;

    logic [7:0] q8;
    logic       co8, zero8;
    logic [5:0] q6;
    logic       co6, zero6;

    longint mq8 = 0, mco8 = 0, mq6 = 0, mco6 = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    universal_shift_counter_n #(.WIDTH(8), .MAX_COUNT(9)) dut8 (
        .Clk(clk), .reset(reset), .EN(en), .A(a), .D(d), .SHAMT(shamt),
        .RSI(rsi), .LSI(lsi), .Q(q8), .CO(co8), .ZERO(zero8)
    );

    universal_shift_counter_n #(.WIDTH(6)) dut6 (
        .Clk(clk), .reset(reset), .EN(en), .A(a), .D(d[5:0]), .SHAMT(shamt),
        .RSI(rsi), .LSI(lsi), .Q(q6), .CO(co6), .ZERO(zero6)
    );

    // Returns co * 2**w + next_q, computed with plain integer arithmetic.
    function automatic longint mstep(input int w, input longint mx, input longint q,
                                     input int op, input longint dv, input int k,
                                     input int si_r, input int si_l);
        longint full = longint'(1) << w;
        longint half = full / 2;
        longint nq = q;
        longint co = 0;
        case (op)
            0: nq = q;
            1: begin nq = (q * 2 + si_r) % full; co = q / half; end
            2: begin nq = si_l * half + q / 2; co = q % 2; end
            3: nq = 0;
            4: nq = full - 1;
            5: if (q >= mx) begin nq = 0; co = 1; end else nq = q + 1;
            6: if (q == 0) begin nq = mx; co = 1; end else nq = q - 1;
            7: nq = dv % full;
            8: begin nq = (q * 2) % full + q / half; co = q / half; end
            9: begin nq = (q % 2) * half + q / 2; co = q % 2; end
            10: begin nq = (q / half) * half + q / 2; co = q % 2; end
            11: if (k >= w) nq = 0;
                else if (k > 0) begin nq = (q << k) % full; co = (q >> (w - k)) % 2; end
            12: if (k >= w) nq = 0;
                else if (k > 0) begin nq = q >> k; co = (q >> (k - 1)) % 2; end
            13: if (q >= mx) begin nq = mx; co = 1; end else nq = q + 1;
            14: if (q == 0) begin nq = 0; co = 1; end else nq = q - 1;
            default: begin
                nq = 0;
                for (int i = 0; i < w; i++)
                    if (((q >> i) % 2) == 1) nq = nq + (longint'(1) << (w - 1 - i));
            end
        endcase
        return co * full + nq;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq8 <= 0; mco8 <= 0; mq6 <= 0; mco6 <= 0;
        end else if (en) begin
            mq8  <= mstep(8, 9, mq8, int'(a), longint'(d), int'(shamt), int'(rsi), int'(lsi)) % 256;
            mco8 <= mstep(8, 9, mq8, int'(a), longint'(d), int'(shamt), int'(rsi), int'(lsi)) / 256;
            mq6  <= mstep(6, 63, mq6, int'(a), longint'(d), int'(shamt), int'(rsi), int'(lsi)) % 64;
            mco6 <= mstep(6, 63, mq6, int'(a), longint'(d), int'(shamt), int'(rsi), int'(lsi)) / 64;
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        check("model_q8", longint'(q8), mq8);
        check("model_co8", longint'(co8), mco8);
        check("model_zero8", longint'(zero8), longint'(mq8 == 0));
        check("model_q6", longint'(q6), mq6);
        check("model_co6", longint'(co6), mco6);
        check("model_zero6", longint'(zero6), longint'(mq6 == 0));
    end

    task automatic op(input logic e, input logic [3:0] opc, input logic [7:0] dv,
                      input logic [2:0] k, input logic r, input logic l);
        en = e; a = opc; d = dv; shamt = k; rsi = r; lsi = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit8(input string name, input logic [7:0] eq, input logic eco);
        check({name, "_q"}, longint'(q8), longint'(eq));
        check({name, "_co"}, longint'(co8), longint'(eco));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lit8("reset", 8'h00, 1'b0);
        check("reset_zero", longint'(zero8), 1);
        reset = 1'b0;

        // reset pulse between edges while counting
        op(1'b1, 4'b0111, 8'd4, 3'd0, 1'b0, 1'b0);
        en = 1'b1; a = 4'b0101;
        @(posedge clk);
        #1 check("precount_q", longint'(q8), 5);
        #1 reset = 1'b1;
        #1 lit8("async_reset", 8'h00, 1'b0);
        check("async_reset_zero", longint'(zero8), 1);
        en = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        op(1'b1, 4'b0111, 8'hA5, 3'd0, 1'b0, 1'b0);
        lit8("load_a5", 8'hA5, 1'b0);
        check("load_a5_q6", longint'(q6), 64'h25);

        // wrap counting
        op(1'b1, 4'b0111, 8'd8, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b0101, 8'd0, 3'd0, 1'b0, 1'b0); lit8("upw_9", 8'd9, 1'b0);
        op(1'b1, 4'b0101, 8'd0, 3'd0, 1'b0, 1'b0); lit8("upw_wrap", 8'd0, 1'b1);
        op(1'b1, 4'b0101, 8'd0, 3'd0, 1'b0, 1'b0); lit8("upw_1", 8'd1, 1'b0);
        op(1'b1, 4'b0011, 8'd0, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b0110, 8'd0, 3'd0, 1'b0, 1'b0); lit8("dnw_wrap", 8'd9, 1'b1);
        op(1'b1, 4'b0111, 8'd200, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b0101, 8'd0, 3'd0, 1'b0, 1'b0); lit8("upw_above", 8'd0, 1'b1);
        op(1'b1, 4'b0111, 8'd200, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b0110, 8'd0, 3'd0, 1'b0, 1'b0); lit8("dnw_above", 8'd199, 1'b0);

        // saturating counting
        op(1'b1, 4'b0111, 8'd9, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1101, 8'd0, 3'd0, 1'b0, 1'b0); lit8("ups_sat", 8'd9, 1'b1);
        op(1'b1, 4'b0111, 8'd1, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1110, 8'd0, 3'd0, 1'b0, 1'b0); lit8("dns_0", 8'd0, 1'b0);
        op(1'b1, 4'b1110, 8'd0, 3'd0, 1'b0, 1'b0); lit8("dns_sat", 8'd0, 1'b1);

        // shifts, rotates, reverse on 1001_0110
        op(1'b1, 4'b0111, 8'h96, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b0001, 8'd0, 3'd0, 1'b1, 1'b0); lit8("shl", 8'h2D, 1'b1);
        op(1'b1, 4'b0111, 8'h96, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1001, 8'd0, 3'd0, 1'b0, 1'b0); lit8("ror", 8'h4B, 1'b0);
        op(1'b1, 4'b0111, 8'h96, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1010, 8'd0, 3'd0, 1'b0, 1'b0); lit8("asr", 8'hCB, 1'b0);
        op(1'b1, 4'b0111, 8'h96, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1111, 8'd0, 3'd0, 1'b0, 1'b0); lit8("rev", 8'h69, 1'b0);
        op(1'b1, 4'b0111, 8'h96, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b0010, 8'd0, 3'd0, 1'b0, 1'b1); lit8("shr", 8'hCB, 1'b0);
        op(1'b1, 4'b0111, 8'h96, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1000, 8'd0, 3'd0, 1'b0, 1'b0); lit8("rol", 8'h2D, 1'b1);
        op(1'b1, 4'b0100, 8'd0, 3'd0, 1'b0, 1'b0); lit8("preset", 8'hFF, 1'b0);
        op(1'b1, 4'b0000, 8'd0, 3'd0, 1'b0, 1'b0); lit8("hold", 8'hFF, 1'b0);

        // barrel shifts on F1
        op(1'b1, 4'b0111, 8'hF1, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1011, 8'd0, 3'd3, 1'b0, 1'b0); lit8("bsl3", 8'h88, 1'b1);
        op(1'b1, 4'b0111, 8'hF1, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1100, 8'd0, 3'd4, 1'b0, 1'b0); lit8("bsr4", 8'h0F, 1'b0);
        op(1'b1, 4'b0111, 8'hF1, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1011, 8'd0, 3'd0, 1'b0, 1'b0); lit8("bsl0", 8'hF1, 1'b0);
        op(1'b1, 4'b1100, 8'd0, 3'd7, 1'b0, 1'b0); lit8("bsr7", 8'h01, 1'b1);
        op(1'b1, 4'b0111, 8'h3F, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1011, 8'd0, 3'd7, 1'b0, 1'b0);
        check("w6_bsl7_q", longint'(q6), 0);
        check("w6_bsl7_co", longint'(co6), 0);
        op(1'b1, 4'b0111, 8'h3F, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b1100, 8'd0, 3'd6, 1'b0, 1'b0);
        check("w6_bsr6_q", longint'(q6), 0);

        // clock enable holds Q and CO
        op(1'b1, 4'b0111, 8'h96, 3'd0, 1'b0, 1'b0);
        op(1'b1, 4'b0001, 8'd0, 3'd0, 1'b0, 1'b0); lit8("pre_en", 8'h2C, 1'b1);
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 4'b0011, 8'd0, 3'd0, 1'b0, 1'b0); lit8("en_low", 8'h2C, 1'b1);
        end
        op(1'b1, 4'b0011, 8'd0, 3'd0, 1'b0, 1'b0); lit8("en_high", 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
